// File: rtl/vlsu_sequencer_if.sv
// Data-memory port used by the vector load/store sequencer: one 32-bit access
// per request, req (enables) / gnt / rvalid handshake.
interface vlsu_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int ELEN   = 32
);
   logic [3:0]        mem_ren;
   logic [3:0]        mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [ELEN-1:0]   mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [ELEN-1:0]   mem_rdata;

   modport master (
      output mem_ren, mem_wen, mem_addr, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_ren, mem_wen, mem_addr, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/vlsu_sequencer.sv
// Element-by-element executor for RVV unit-stride, strided and indexed loads/stores:
// one memory access per active element, load results assembled for write-back.
module vlsu_sequencer #(
   parameter int ELEN   = 32,
   parameter int VLMAX  = 8,
   parameter int ADDR_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    is_store,
   input  logic [1:0]              mode,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [ADDR_W-1:0]       stride,
   input  logic [3:0]              vl,
   input  logic [VLMAX*ELEN-1:0]   vs3_data,
   input  logic [VLMAX*ELEN-1:0]   vidx_data,
   vlsu_sequencer_if.master        mem,
   output logic [VLMAX*ELEN-1:0]   vd_data,
   output logic [VLMAX-1:0]        vd_mask,
   output logic                    vd_we,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int IDX_W = (VLMAX > 1) ? $clog2(VLMAX) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_e;

   state_e                          state_q, state_d;
   logic                            isStore_q, isStore_d;
   logic                            err_q, err_d;
   logic [1:0]                      mode_q, mode_d;
   logic [ADDR_W-1:0]               base_q, base_d;
   logic [ADDR_W-1:0]               stride_q, stride_d;
   logic [ADDR_W-1:0]               addr_q, addr_d;
   logic [3:0]                      effVl_q, effVl_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [VLMAX-1:0][ELEN-1:0]      vs3_q, vs3_d;
   logic [VLMAX-1:0][ELEN-1:0]      vidx_q, vidx_d;
   logic [VLMAX-1:0][ELEN-1:0]      vdData_q, vdData_d;
   logic [VLMAX-1:0]                vdMask_q, vdMask_d;

   logic [3:0]                      effVlIn;
   logic [IDX_W-1:0]                nextIdx;
   logic [ADDR_W-1:0]               nextAddr;
   logic                            lastElem;
   logic                            reqActive;

   assign effVlIn  = (vl > 4'(VLMAX)) ? 4'(VLMAX) : vl;
   assign nextIdx  = idx_q + IDX_W'(1);
   assign lastElem = (4'(idx_q) == (effVl_q - 4'd1));

   // addr_q always holds the address of the current element; this is the
   // address of the following one (strided uses a running accumulator)
   always_comb begin
      nextAddr = base_q + ADDR_W'(vidx_q[nextIdx]);
      case (mode_q)
         2'b00:   nextAddr = addr_q + ADDR_W'(4);
         2'b01:   nextAddr = addr_q + stride_q;
         default: nextAddr = base_q + ADDR_W'(vidx_q[nextIdx]);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         isStore_q <= 1'b0;
         err_q     <= 1'b0;
         mode_q    <= 2'b00;
         base_q    <= '0;
         stride_q  <= '0;
         addr_q    <= '0;
         effVl_q   <= '0;
         idx_q     <= '0;
         vs3_q     <= '0;
         vidx_q    <= '0;
         vdData_q  <= '0;
         vdMask_q  <= '0;
      end else begin
         state_q   <= state_d;
         isStore_q <= isStore_d;
         err_q     <= err_d;
         mode_q    <= mode_d;
         base_q    <= base_d;
         stride_q  <= stride_d;
         addr_q    <= addr_d;
         effVl_q   <= effVl_d;
         idx_q     <= idx_d;
         vs3_q     <= vs3_d;
         vidx_q    <= vidx_d;
         vdData_q  <= vdData_d;
         vdMask_q  <= vdMask_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      isStore_d = isStore_q;
      err_d     = err_q;
      mode_d    = mode_q;
      base_d    = base_q;
      stride_d  = stride_q;
      addr_d    = addr_q;
      effVl_d   = effVl_q;
      idx_d     = idx_q;
      vs3_d     = vs3_q;
      vidx_d    = vidx_q;
      vdData_d  = vdData_q;
      vdMask_d  = vdMask_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               isStore_d = is_store;
               mode_d    = mode;
               base_d    = base_addr;
               stride_d  = stride;
               vs3_d     = vs3_data;
               vidx_d    = vidx_data;
               effVl_d   = effVlIn;
               idx_d     = '0;
               err_d     = (mode == 2'b11);
               addr_d    = (mode == 2'b10) ? (base_addr + ADDR_W'(vidx_data[ELEN-1:0])) : base_addr;
               if (!is_store) begin
                  vdMask_d = '0;
               end
               state_d = ((mode == 2'b11) || (effVlIn == 4'd0)) ? FIN : REQ;
            end
         end
         REQ: begin
            if (mem.mem_gnt) begin
               if (!isStore_q) begin
                  state_d = WAIT;
               end else if (lastElem) begin
                  state_d = FIN;
               end else begin
                  idx_d  = nextIdx;
                  addr_d = nextAddr;
               end
            end
         end
         WAIT: begin
            if (mem.mem_rvalid) begin
               vdData_d[idx_q] = mem.mem_rdata;
               vdMask_d[idx_q] = 1'b1;
               if (lastElem) begin
                  state_d = FIN;
               end else begin
                  idx_d   = nextIdx;
                  addr_d  = nextAddr;
                  state_d = REQ;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request lines are only non-zero in REQ, so everything idles at zero
   assign reqActive     = (state_q == REQ);
   assign mem.mem_ren   = (reqActive && !isStore_q) ? 4'hF : 4'h0;
   assign mem.mem_wen   = (reqActive &&  isStore_q) ? 4'hF : 4'h0;
   assign mem.mem_addr  = reqActive ? addr_q : '0;
   assign mem.mem_wdata = (reqActive && isStore_q) ? vs3_q[idx_q] : '0;

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == FIN);
   assign err     = (state_q == FIN) && err_q;
   assign vd_we   = (state_q == FIN) && !isStore_q && !err_q && (effVl_q != 4'd0);
   assign vd_data = vdData_q;
   assign vd_mask = vdMask_q;

endmodule
